// File: rtl/tb_uart_pkg.sv
// Shared types and constants for the bench-side UART transceiver.
package tb_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int unsigned UART_DATA_BITS            = 8;
  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 4167;

endpackage

// File: rtl/tb_uart_if.sv
// Handshake and serial signals of the bench-side UART transceiver.
interface tb_uart_if;
  import tb_uart_pkg::*;

  logic                      tx_start;
  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_busy;
  logic                      tx_clear_req;
  logic                      ser_tx;
  logic                      ser_rx;
  logic [UART_DATA_BITS-1:0] recv_pattern;
  logic                      recv_valid;
  logic                      recv_err;

  modport master (
    output tx_start, tx_data, ser_rx,
    input  tx_busy, tx_clear_req, ser_tx, recv_pattern, recv_valid, recv_err
  );

  modport slave (
    input  tx_start, tx_data, ser_rx,
    output tx_busy, tx_clear_req, ser_tx, recv_pattern, recv_valid, recv_err
  );
endinterface

// File: rtl/tb_uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM and recv_* pulses.
module tb_uart_rx
  import tb_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      ser_rx_i,
  output logic [UART_DATA_BITS-1:0] recv_pattern_o,
  output logic                      recv_valid_o,
  output logic                      recv_err_o
);

  localparam int unsigned     CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(UART_DATA_BITS - 1);

  logic [1:0]                sync_q;
  logic                      rx;
  uart_state_e               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [UART_DATA_BITS-1:0] pattern_q, pattern_d;
  logic                      valid_q, valid_d;
  logic                      err_q, err_d;

  assign rx = sync_q[1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q    <= '1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      pattern_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], ser_rx_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      pattern_q <= pattern_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    pattern_d = pattern_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx) state_d = START;
      end
      START: begin
        // A start bit still low at its midpoint is real; otherwise a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx, shreg_q[UART_DATA_BITS-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx) begin
            pattern_d = shreg_q;
            valid_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    recv_pattern_o = pattern_q;
    recv_valid_o   = valid_q;
    recv_err_o     = err_q;
  end

endmodule

// File: rtl/tb_uart_xcvr.sv
// Bench-side UART transceiver: level-handshake TX FSM plus independent RX path.
module tb_uart_xcvr
  import tb_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic     clock,
  input  logic     resetb,
  tb_uart_if.slave bus
);

  localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_BITS - 1);

  uart_state_e               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                      armed_q, armed_d;
  logic                      clr_q, clr_d;
  logic                      ser_tx;
  logic                      tx_busy;

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      armed_q <= 1'b1;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      armed_q <= armed_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    armed_d = armed_q;
    clr_d   = clr_q;
    // Re-arming only on a low tx_start keeps a held request from re-sending.
    if (!bus.tx_start) begin
      armed_d = 1'b1;
      clr_d   = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (bus.tx_start && armed_q) begin
          state_d = START;
          shreg_d = bus.tx_data;
          cnt_d   = '0;
          armed_d = 1'b0;
          clr_d   = 1'b1;
        end
      end
      START: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ser_tx  = 1'b1;
    tx_busy = (state_q != IDLE);
    unique case (state_q)
      START:   ser_tx = 1'b0;
      DATA:    ser_tx = shreg_q[idx_q];
      default: ser_tx = 1'b1;
    endcase
  end

  assign bus.ser_tx       = ser_tx;
  assign bus.tx_busy      = tx_busy;
  assign bus.tx_clear_req = clr_q;

  tb_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i          (clock),
    .rst_ni         (resetb),
    .ser_rx_i       (bus.ser_rx),
    .recv_pattern_o (bus.recv_pattern),
    .recv_valid_o   (bus.recv_valid),
    .recv_err_o     (bus.recv_err)
  );

endmodule
